// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the MEM-stage data memory bridge.
// Holds the bridge FSM encodings, the abort data pattern and a small helper.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  // Load data returned when a bus transaction is abandoned by the watchdog
  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_bridge_watchdog.sv
// dmem_watchdog: counts consecutive cycles the bridge spends waiting for
// bus_ack and flags expiry on the TIMEOUT-th waiting cycle.
// Only instantiated when DMEM_TIMEOUT_EN is defined.
module dmem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter advances while waiting and restarts from zero whenever waiting stops
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the MEM stage's single-cycle load/store into a req/ack
// bus transaction, stalling the pipeline until the access completes.
// Optional feature macro: DMEM_TIMEOUT_EN adds a watchdog that aborts an
// unacknowledged request after TIMEOUT cycles and raises sticky bus_err.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_en,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
`ifdef DMEM_TIMEOUT_EN
  output logic              bus_err,
`endif
  output logic              misalign
);

  dmem_state_e       state_q,     state_d;
  logic              bus_we_q,    bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] mem_din_q,   mem_din_d;
  logic              misalign_q,  misalign_d;
  logic              stall_raw;

`ifdef DMEM_TIMEOUT_EN
  logic bus_err_q, bus_err_d;
  logic wd_expired;

  dmem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state_q == DMEM_REQ),
    .expired (wd_expired)
  );

  assign bus_err = bus_err_q;
`endif

  // Next-state and datapath latching; an ack only counts while the request is up
  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_din_d   = mem_din_q;
    misalign_d  = misalign_q;
    stall_raw   = 1'b0;
    bus_req     = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    bus_err_d   = bus_err_q;
`endif
    case (state_q)
      DMEM_IDLE: begin
        if (mem_ren || mem_wen) begin
          stall_raw   = 1'b1;
          bus_we_d    = mem_wen;
          bus_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
          bus_wdata_d = mem_dout;
          if (is_misaligned(mem_addr[1:0])) begin
            misalign_d = 1'b1;
          end
          state_d = DMEM_REQ;
        end
      end
      DMEM_REQ: begin
        stall_raw = 1'b1;
        bus_req   = 1'b1;
        if (bus_ack) begin
          if (!bus_we_q) begin
            mem_din_d = bus_rdata;
          end
          state_d = DMEM_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (wd_expired) begin
          mem_din_d = DATA_W'(DMEM_ERR_DATA);
          bus_err_d = 1'b1;
          state_d   = DMEM_DONE;
        end
`endif
      end
      DMEM_DONE: begin
        if (mem_en) begin
          state_d = DMEM_IDLE;
        end
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  // State and bus registers, all cleared by reset even mid-transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DMEM_IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_din_q   <= '0;
      misalign_q  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_din_q   <= mem_din_d;
      misalign_q  <= misalign_d;
`ifdef DMEM_TIMEOUT_EN
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  // The idle-cycle stall is combinational from mem_ren/mem_wen, so it is
  // masked while reset is held to keep the pipeline free during reset
  assign mem_stall = rst_n && stall_raw;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign mem_din   = mem_din_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge. Expected load data is queued when an
// access is launched and popped when the bridge reaches its completion cycle.
// Define DMEM_TIMEOUT_EN to also exercise the watchdog abort path.
module tb_dmem_bridge;

  logic        clk;
  logic        rst_n;
  logic        memRen;
  logic        memWen;
  logic [31:0] memAddr;
  logic [31:0] memDout;
  logic        memEn;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        busAck;
  logic [31:0] busRdata;
  logic        misalign;
`ifdef DMEM_TIMEOUT_EN
  logic        bus_err;
`endif

  int          vectorCount;
  int          errorCount;
  logic [31:0] expQ[$];
  logic [31:0] expDin;
  logic        expMis;

  dmem_bridge #(
    .ADDR_W (32),
    .DATA_W (32)
`ifdef DMEM_TIMEOUT_EN
    ,
    .TIMEOUT (8)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ren   (memRen),
    .mem_wen   (memWen),
    .mem_addr  (memAddr),
    .mem_dout  (memDout),
    .mem_en    (memEn),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (busAck),
    .bus_rdata (busRdata),
`ifdef DMEM_TIMEOUT_EN
    .bus_err   (bus_err),
`endif
    .misalign  (misalign)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete access: launch, wait states, completion, optional DONE hold.
  // Entered and left just after a rising edge with the bridge idle.
  task automatic applyStimulus(input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] dout,
                               input logic [31:0] rdata, input int waits,
                               input int holdCycles);
    int stallCount;
    logic [31:0] expAddr;
    logic expWe;
    expAddr = {addr[31:2], 2'b00};
    expWe   = wen;
    if (ren && !wen) expDin = rdata;
    expQ.push_back(expDin);
    if (addr[1:0] != 2'b00) expMis = 1'b1;

    memRen = ren; memWen = wen; memAddr = addr; memDout = dout; memEn = 1'b0;
    stallCount = 0;
    @(negedge clk);
    if (mem_stall) stallCount++;
    checkOutput("idle_stall", {31'd0, mem_stall}, 32'd1);
    checkOutput("idle_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    memRen = 1'b0; memWen = 1'b0; memAddr = 32'hFFFF_FFF0; memDout = 32'h0BAD_0BAD;

    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      if (mem_stall) stallCount++;
      checkOutput("req_up", {31'd0, bus_req}, 32'd1);
      checkOutput("bus_addr", bus_addr, expAddr);
      checkOutput("bus_we", {31'd0, bus_we}, {31'd0, expWe});
      if (expWe) checkOutput("bus_wdata", bus_wdata, dout);
      if (k == waits) begin
        busAck = 1'b1; busRdata = rdata;
      end else begin
        busRdata = $urandom;
      end
      @(posedge clk); #1;
      busAck = 1'b0;
      busRdata = $urandom;
    end

    @(negedge clk);
    if (mem_stall) stallCount++;
    checkOutput("stall_cycles", stallCount, 32'(2 + waits));
    checkOutput("done_req", {31'd0, bus_req}, 32'd0);
    checkOutput("mem_din", mem_din, expQ.pop_front());
    checkOutput("misalign", {31'd0, misalign}, {31'd0, expMis});

    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hold_stall", {31'd0, mem_stall}, 32'd0);
      checkOutput("hold_req", {31'd0, bus_req}, 32'd0);
      checkOutput("hold_din", mem_din, expDin);
    end
    memEn = 1'b1;
    @(posedge clk); #1;
    memEn = 1'b0;
  endtask

  // Main sequence
  initial begin
    vectorCount = 0; errorCount = 0;
    expDin = 32'd0; expMis = 1'b0;
    rst_n = 1'b0; memRen = 1'b0; memWen = 1'b0; memAddr = 32'd0; memDout = 32'd0;
    memEn = 1'b0; busAck = 1'b0; busRdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", {31'd0, bus_req}, 32'd0);
    checkOutput("rst_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("rst_din", mem_din, 32'd0);
    checkOutput("rst_addr", bus_addr, 32'd0);
    checkOutput("rst_mis", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] read, no wait states");
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 0);
    $display("[TB] write, five wait states");
    applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h5555_AAAA, 5, 0);
    $display("[TB] read, held in DONE for three cycles");
    applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'hA5A5_5A5A, 2, 3);
    $display("[TB] read+write together, misaligned");
    applyStimulus(1'b1, 1'b1, 32'h0000_0006, 32'h1111_2222, 32'h9999_9999, 1, 0);
    $display("[TB] aligned read, misalign stays set");
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h0F0F_0F0F, 0, 0);

    $display("[TB] reset during REQ");
    memRen = 1'b1; memAddr = 32'h0000_0040;
    @(posedge clk); #1;
    memRen = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_req", {31'd0, bus_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", {31'd0, bus_req}, 32'd0);
    checkOutput("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("mid_rst_din", mem_din, 32'd0);
    checkOutput("mid_rst_mis", {31'd0, misalign}, 32'd0);
    expDin = 32'd0; expMis = 1'b0;
    @(negedge clk);
    busAck = 1'b1; busRdata = 32'hBAAD_F00D;
    @(posedge clk); #1;
    busAck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busAck = 1'b1; busRdata = 32'hFEED_FACE;
    @(posedge clk); #1;
    busAck = 1'b0;
    @(negedge clk);
    checkOutput("late_ack_req", {31'd0, bus_req}, 32'd0);
    checkOutput("late_ack_stall", {31'd0, mem_stall}, 32'd0);
    checkOutput("late_ack_din", mem_din, 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0050, 32'h0, 32'h600D_CAFE, 3, 0);

`ifdef DMEM_TIMEOUT_EN
    begin
      int reqCycles;
      $display("[TB] watchdog abort");
      checkOutput("err_before", {31'd0, bus_err}, 32'd0);
      memRen = 1'b1; memAddr = 32'h0000_0060;
      @(posedge clk); #1;
      memRen = 1'b0;
      reqCycles = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!bus_req) break;
        reqCycles++;
        @(posedge clk); #1;
      end
      checkOutput("timeout_cycles", reqCycles, 32'd8);
      checkOutput("timeout_din", mem_din, 32'hDEAD_BEEF);
      checkOutput("timeout_err", {31'd0, bus_err}, 32'd1);
      checkOutput("timeout_stall", {31'd0, mem_stall}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
    $finish;
  end

endmodule
